debounce_filter: RTL
====================

# debounce_filter

Input conditioning stage directly upstream of the rising-edge detector. Takes a raw, bouncing switch/button level and produces a clean, glitch-free level for the detector's `signal_in`. Also produces a one-cycle press tick for consumers that need no separate edge stage. A four-state FSM and a stability counter accept a new level only after it has been held unchanged for a programmable number of clock cycles.

## Interface
- `CNT_W`, 20, width of the stability counter.
- `STABLE_CYCLES`, 500000, consecutive cycles a new level must hold before acceptance (10 ms at 50 MHz). Legal range 1 ≤ STABLE_CYCLES ≤ 2^CNT_W − 1.
- `clk`  in  1  single clock, rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `sw_in`  in  1  raw switch level; may be asynchronous and bouncing.
- `db_level`  out  1  debounced level, registered; drives the edge detector's `signal_in`.
- `db_tick`  out  1  one-cycle pulse on each accepted 0→1 transition, registered.
- `state_dbg`  out  2  current FSM state encoding, for debug/LEDs.

## Operation
- `s` is the sampled input: `sw_in` itself, or the synchroniser output (see Configuration).
- FSM states and encodings:
  - `ZERO`=00: stable low; `db_level`=0.
  - `WAIT1`=01: candidate high; `db_level`=0.
  - `ONE`=10: stable high; `db_level`=1.
  - `WAIT0`=11: candidate low; `db_level`=1.
- Transitions, all evaluated at each rising `clk` edge:
  - `ZERO`: s=1 → `WAIT1`, cnt←0. Otherwise stay.
  - `WAIT1`: s=0 → `ZERO`, cnt←0. s=1 and cnt==STABLE_CYCLES−1 → `ONE`, `db_level`←1, `db_tick`←1. s=1 otherwise → cnt←cnt+1.
  - `ONE`: s=0 → `WAIT0`, cnt←0. Otherwise stay.
  - `WAIT0`: s=1 → `ONE`, cnt←0. s=0 and cnt==STABLE_CYCLES−1 → `ZERO`, `db_level`←0, no tick. s=0 otherwise → cnt←cnt+1.
- `db_tick` defaults to 0 every cycle. It is asserted only on the `WAIT1`→`ONE` edge, so it never lasts more than one cycle.
- Counter is unsigned CNT_W bits. It never exceeds STABLE_CYCLES−1, so it never wraps.
- A bounce (opposite level for even one sample) while in a WAIT state aborts the candidate and restarts the full count on the next attempt. A partial count is never retained.
- `db_level` and `db_tick` are driven from flops, never combinationally from `sw_in`.

## Timing
- Reset: state=`ZERO`, cnt=0, `db_level`=0, `db_tick`=0, `state_dbg`=00, synchroniser flops=0. All take effect immediately on `reset` assertion, independent of `clk`.
- Reset mid-count discards all progress. No tick is produced by reset.
- If `sw_in` is already high when reset releases, the normal `WAIT1` path runs and a `db_tick` is produced after acceptance.
- Latency: let edge k be the first edge sampling s=1 in `ZERO`. If s stays 1 through edge k+STABLE_CYCLES, then `db_level` rises and `db_tick` pulses for the cycle following edge k+STABLE_CYCLES.
  - Minimum high run accepted: STABLE_CYCLES+1 consecutive samples.
  - Falling transitions are symmetric.
- STABLE_CYCLES=1: acceptance occurs on the edge immediately after entry to the WAIT state.

## Configuration
- Macro `DEBOUNCE_SYNC_EN`.
- Defined: `sw_in` passes through a 2-flop synchroniser (reset to 0) before the FSM, so s = `sw_in` delayed 2 cycles. All latencies above gain +2 cycles relative to `sw_in`.
- Undefined: s = `sw_in` directly, with no added latency. `sw_in` must then already be synchronous to `clk`.

## Test plan
All scenarios use STABLE_CYCLES=4, CNT_W=3, `DEBOUNCE_SYNC_EN` undefined unless stated.
- Reset with `sw_in`=0, hold 10 cycles → `db_level`=0, `db_tick`=0, `state_dbg`=00 throughout.
- `sw_in`=1 first sampled at edge k, held → `state_dbg`=01 after edge k. `db_level`=1 and a single-cycle `db_tick`=1 after edge k+4. `state_dbg`=10 thereafter.
- Bounce: 1,1,0,1,1,1,1,1 sampled from `ZERO` → abort to `ZERO` at the 0. Acceptance occurs 4 edges after the re-entry to `WAIT1`, with exactly one tick.
- From `ONE`, drive `sw_in`=0 held → `db_level` falls after edge k+4, and `db_tick` stays 0. A 0,0,1 glitch returns to `ONE` with `db_level` held at 1.
- Assert `reset` asynchronously while in `WAIT1` with cnt=2 → outputs and state return to reset values before the next `clk` edge. After release with `sw_in`=1, a full 4-cycle count is required.
- With `DEBOUNCE_SYNC_EN` defined, repeat the second scenario → `db_level` and `db_tick` occur exactly 2 cycles later than without the macro.

Source files
------------

// File: rtl/debounce_filter.sv
// -----------------------------------------------------------------------------
// debounce_filter
//
// Input conditioning stage for a bouncing switch/button. A new level is only
// accepted after the sampled input has held that level for STABLE_CYCLES
// consecutive clock edges following entry to a candidate (WAIT) state. Any
// opposite sample during a WAIT state aborts the candidate. The next attempt
// then starts a full count from zero.
//
// Optional feature (macro DEBOUNCE_SYNC_EN):
//   defined   : sw_in passes through a 2-flop synchroniser before the FSM.
//               This adds 2 cycles of latency.
//   undefined : sw_in feeds the FSM directly and must already be synchronous
//               to clk.
//
// Parameters:
//   CNT_W          width of the stability counter
//   STABLE_CYCLES  cycles a new level must hold (1 .. 2^CNT_W-1)
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   sw_in      in   raw switch level
//   db_level   out  debounced level (registered)
//   db_tick    out  one-cycle pulse on each accepted 0->1 transition (registered)
//   state_dbg  out  current FSM state encoding
// -----------------------------------------------------------------------------
module debounce_filter #(
  parameter int CNT_W         = 20,
  parameter int STABLE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sw_in,
  output logic       db_level,
  output logic       db_tick,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    ZERO  = 2'b00,
    WAIT1 = 2'b01,
    ONE   = 2'b10,
    WAIT0 = 2'b11
  } state_t;

  // The count reached on the edge that accepts the candidate level.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 1);

  logic s;

`ifdef DEBOUNCE_SYNC_EN
  logic [1:0] sync_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], sw_in};
    end
  end

  assign s = sync_reg[1];
`else
  assign s = sw_in;
`endif

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             level_reg, level_next;
  logic             tick_reg, tick_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ZERO;
      cnt_reg   <= '0;
      level_reg <= 1'b0;
      tick_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      level_reg <= level_next;
      tick_reg  <= tick_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    level_next = level_reg;
    tick_next  = 1'b0;

    case (state_reg)
      ZERO: begin
        if (s) begin
          state_next = WAIT1;
          cnt_next   = '0;
        end
      end
      WAIT1: begin
        if (!s) begin
          // Bounce: drop the candidate and any partial count.
          state_next = ZERO;
          cnt_next   = '0;
        end else if (cnt_reg == LAST_CNT) begin
          state_next = ONE;
          cnt_next   = '0;
          level_next = 1'b1;
          tick_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ONE: begin
        if (!s) begin
          state_next = WAIT0;
          cnt_next   = '0;
        end
      end
      WAIT0: begin
        if (s) begin
          state_next = ONE;
          cnt_next   = '0;
        end else if (cnt_reg == LAST_CNT) begin
          // Falling acceptance never produces a tick.
          state_next = ZERO;
          cnt_next   = '0;
          level_next = 1'b0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = ZERO;
        cnt_next   = '0;
        level_next = 1'b0;
      end
    endcase
  end

  assign db_level  = level_reg;
  assign db_tick   = tick_reg;
  assign state_dbg = state_reg;

endmodule
